// File: rtl/timer_down_nbit.sv
// Down-counting timer: loads a period, counts to zero and pulses done at terminal count.
// Optional auto-reload turns it into a gap-free period-N tick generator.
module timer_down_nbit #(
    parameter int CNT_WIDTH = 3
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] load_value_i,
    input  logic                 start_i,
    input  logic                 pause_i,
    input  logic                 auto_reload_i,
    output logic [CNT_WIDTH-1:0] counter_o,
    output logic                 busy_o,
    output logic                 done_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] ZERO = '0;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 done_q, done_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            period_q <= ZERO;
            cnt_q    <= ZERO;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;

        if (load_i) begin
            // Load aborts any run and swallows a coincident start.
            period_d = load_value_i;
            cnt_d    = load_value_i;
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i && (period_q != ZERO)) begin
                        cnt_d   = period_q;
                        state_d = RUN;
                    end
                end
                RUN, PAUSED: begin
                    if (pause_i) begin
                        state_d = PAUSED;
                    end else if (cnt_q == ONE) begin
                        done_d = 1'b1;
                        if (auto_reload_i) begin
                            cnt_d   = period_q;
                            state_d = RUN;
                        end else begin
                            cnt_d   = ZERO;
                            state_d = IDLE;
                        end
                    end else if (cnt_q > ONE) begin
                        cnt_d   = cnt_q - ONE;
                        state_d = RUN;
                    end else begin
                        // Zero count while running is unreachable; fall back to idle.
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign counter_o = cnt_q;
    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;

endmodule

// File: tb/tb_timer_down_nbit.sv
// Scoreboard bench for timer_down_nbit: driver pushes model predictions, monitor pops
// and compares the registered outputs one step after every rising edge.
module tb_timer_down_nbit;

    localparam int W = 3;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         busy;
        logic         done;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset, load, start, pause, auto_reload;
    logic [W-1:0] load_value;
    logic [W-1:0] counter;
    logic         busy, done;

    int total = 0;
    int bad   = 0;
    exp_t scb[$];

    // Reference model state: plain integers, no explicit pause state.
    int m_period = 0;
    int m_cnt    = 0;
    bit m_busy   = 0;
    bit m_done   = 0;

    timer_down_nbit #(.CNT_WIDTH(W)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .load_i       (load),
        .load_value_i (load_value),
        .start_i      (start),
        .pause_i      (pause),
        .auto_reload_i(auto_reload),
        .counter_o    (counter),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    function automatic void model_step(bit r, bit l, int lv, bit s, bit p, bit ar);
        m_done = 0;
        if (r) begin
            m_period = 0; m_cnt = 0; m_busy = 0;
        end else if (l) begin
            m_period = lv; m_cnt = lv; m_busy = 0;
        end else if (!m_busy) begin
            if (s && m_period > 0) begin
                m_cnt = m_period; m_busy = 1;
            end
        end else if (!p) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_done = 1;
                if (ar) m_cnt = m_period;
                else    m_busy = 0;
            end
        end
    endfunction

    // Apply one cycle of inputs, predict the post-edge outputs, then wait for the next negedge.
    task automatic cyc(bit r, bit l, int lv, bit s, bit p, bit ar);
        exp_t e;
        reset = r; load = l; load_value = W'(lv); start = s; pause = p; auto_reload = ar;
        model_step(r, l, lv, s, p, ar);
        e.cnt  = W'(m_cnt);
        e.busy = m_busy;
        e.done = m_done;
        scb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(int n, bit ar = 0);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, ar);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (scb.size() == 0) begin
                total++; bad++;
                $display("FAIL scb_empty: output at %0t with no prediction", $time);
            end else begin
                e = scb.pop_front();
                total++;
                if (counter !== e.cnt) begin
                    bad++;
                    $display("FAIL counter @%0t: got %0d want %0d", $time, counter, e.cnt);
                end
                total++;
                if (busy !== e.busy) begin
                    bad++;
                    $display("FAIL busy @%0t: got %b want %b", $time, busy, e.busy);
                end
                total++;
                if (done !== e.done) begin
                    bad++;
                    $display("FAIL done @%0t: got %b want %b", $time, done, e.done);
                end
            end
        end
    end

    // Driver
    initial begin
        int drain;
        // Reset for 2 cycles, then a start that must be ignored (period 0)
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        idle(2);
        // One-shot of 5
        cyc(0, 1, 5, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        idle(8);
        // Auto-reload of 3, then drop auto_reload
        cyc(0, 1, 3, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 1);
        idle(10, 1);
        idle(5, 0);
        // Auto-reload with N=1: done held high
        cyc(0, 1, 1, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 1);
        idle(6, 1);
        cyc(0, 1, 0, 0, 0, 0);
        // Pause for 2 cycles at counter=4
        cyc(0, 1, 6, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        idle(2);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        idle(7);
        // Pause while counter=1
        cyc(0, 1, 3, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        idle(2);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0);
        idle(3);
        // Load+start at counter=2 aborts, then count 7..0
        cyc(0, 1, 5, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        idle(3);
        cyc(0, 1, 7, 1, 0, 0);
        idle(2);
        cyc(0, 0, 0, 1, 0, 0);
        idle(9);
        // Start during run is ignored
        cyc(0, 1, 4, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        idle(5);
        // Reset mid-run at counter=3, following start ignored
        cyc(0, 1, 5, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        idle(2);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        idle(2);
        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) < 2),
                ($urandom_range(0, 99) < 6),
                int'($urandom_range(0, (1 << W) - 1)),
                ($urandom_range(0, 99) < 40),
                ($urandom_range(0, 99) < 20),
                ($urandom_range(0, 99) < 50));
        end
        idle(1);
        // Bounded drain of outstanding predictions
        drain = 0;
        while (scb.size() != 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        if (scb.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: %0d predictions left, want 0", scb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
